des_fp_tx: RTL
==============

# des_fp_tx

Output stage of the DES datapath. Accepts the round-16 halves (L16, R16) from the round engine, applies the pre-output swap and the Final Permutation (IP⁻¹), and streams the 64-bit result out as eight bytes, MSB first, over a valid/ready interface. It mirrors the input-side Initial Permutation block and sits between the last round and the byte-wide output port.

## Interface
Parameters:
- none; all widths are fixed by DES.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  L16/R16 pair is presented
- in_ready  out  1  block can accept a pair this cycle
- l16  in  32  left half after round 16
- r16  in  32  right half after round 16
- out_valid  out  1  out_data holds a valid byte
- out_ready  in  1  sink accepts the byte
- out_data  out  8  ciphertext/plaintext byte
- out_last  out  1  high on byte 7 of a block
- busy  out  1  a block is being serialized, or a block is held

## Operation
- Bit numbering: DES bit 1 = bit [63], DES bit 64 = bit [0].
- Pre-output: pre = {r16, l16}; the halves are swapped.
- FP: output DES bit k = pre DES bit FP[k]. FP is the standard inverse of IP. Its first row is 40 8 48 16 56 24 64 32, and its last row is 33 1 41 9 49 17 57 25.
  - Required property: FP(IP(x)) = x for all x.
- Handshake: a transfer occurs when valid && ready on the same edge.
  - The FP result is computed combinationally from l16/r16 and written into a 64-bit shift register on the accepting edge.
- State machine:
  - IDLE: out_valid=0, in_ready=1.
    - On in accept → SEND with byte count cnt=0.
  - SEND: out_valid=1, out_data=shift[63:56], out_last=(cnt==7).
    - On out handshake: shift left 8 and cnt++.
    - On the handshake with cnt==7 → IDLE, unless a next block is available (see Configuration).
- While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- l16/r16 are sampled only on the accepting edge.
  - in_valid with in_ready=0 has no effect.
- Reset values: out_valid=0, out_data=8'h00, out_last=0, busy=0, in_ready=1.
  - State is IDLE, cnt=0, the shift register and holding register are cleared, and the hold-full flag is cleared.
- Reset mid-block: any partially sent or held block is discarded. No further bytes of that block appear.

## Timing
- Latency: accept on edge N → out_valid=1 with byte 0 visible after edge N.
- Throughput without stalls:
  - Prefetch out: 8 byte cycles + 1 idle cycle per block.
  - Prefetch in: 8 cycles per block, with no gap.
- out_valid never drops between bytes of one block.
- rst overrides all same-cycle handshakes.

## Configuration
- DES_FP_PREFETCH_EN undefined:
  - in_ready = (state==IDLE).
  - Blocks are serialized one at a time, with a one-cycle bubble after out_last.
- DES_FP_PREFETCH_EN defined: adds a 64-bit holding register plus a hold-full flag.
  - in_ready = !hold_full. Accepts during SEND go into the holding register.
  - On the cnt==7 handshake with hold_full=1: the shift register loads from hold, hold_full clears, cnt=0, state stays SEND, and out_valid stays 1.
  - Accept in IDLE goes straight to the shift register.
  - Accept on the same edge as the cnt==7 handshake with hold empty also loads straight into the shift register.
  - Accept in SEND with no final handshake sets hold_full.

## Structure
- Shared package des_pkg:
  - FP table constant as 64 entries of DES bit numbers. The IP table lives alongside it.
  - DES_BLOCK_W=64, DES_HALF_W=32.
  - State enum {IDLE, SEND}.
- Sub-module des_fp: pure combinational permutation, {r16,l16} → 64-bit FP result. It is reusable by the model and checker.
- des_fp_tx contains the FSM, byte counter, shift register, and the optional holding register.

## Test plan
- Reset, then l16=32'h43423234, r16=32'h0A4CD995, out_ready=1 → bytes 85 E8 13 54 0F 0A B4 05, with out_last only on 05.
- Round-trip: l16=32'hF0AAF0AA, r16=32'hCC00CCFF → bytes 01 23 45 67 89 AB CD EF.
- Backpressure: deassert out_ready for 3 cycles at byte 3 → byte 54 (from the first vector) is held stable and no byte is lost or duplicated.
- Back-to-back: two blocks offered continuously, out_ready=1.
  - Macro off: 17 cycles from first byte to last byte, with one bubble.
  - Macro on: 16 cycles, contiguous.
- Reset mid-block: assert rst after byte 2 → next cycle out_valid=0, in_ready=1. A new block then streams from byte 0.
- Macro on, simultaneous accept and final-byte handshake with hold empty → next byte is byte 0 of the new block, and hold_full stays 0.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES definitions: block widths, output FSM states and the IP / FP permutation tables.
// Bit convention: DES bit 1 is vector bit [63], DES bit 64 is vector bit [0].
package des_pkg;

    localparam int DES_BLOCK_W = 64;
    localparam int DES_HALF_W  = 32;

    typedef enum logic [0:0] {IDLE, SEND} tx_state_t;

    localparam int FP_TABLE [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam int IP_TABLE [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    function automatic logic [DES_BLOCK_W-1:0] fp_permute(input logic [DES_BLOCK_W-1:0] pre);
        logic [DES_BLOCK_W-1:0] res;
        res = '0;
        for (int k = 0; k < DES_BLOCK_W; k++)
            res[63-k] = pre[64-FP_TABLE[k]];
        return res;
    endfunction

    function automatic logic [DES_BLOCK_W-1:0] ip_permute(input logic [DES_BLOCK_W-1:0] blk);
        logic [DES_BLOCK_W-1:0] res;
        res = '0;
        for (int k = 0; k < DES_BLOCK_W; k++)
            res[63-k] = blk[64-IP_TABLE[k]];
        return res;
    endfunction

endpackage

// File: rtl/des_fp_tx_if.sv
// Handshake bundle of the DES output stage: half-block input side and byte-wide output side.
interface des_fp_tx_if;
    import des_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DES_HALF_W-1:0] l16;
    logic [DES_HALF_W-1:0] r16;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            out_data;
    logic                  out_last;

    modport slave (
        input  in_valid, l16, r16, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, l16, r16, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/des_fp.sv
// Pure combinational pre-output swap plus Final Permutation (IP^-1) of the round-16 halves.
module des_fp
    import des_pkg::*;
(
    input  logic [DES_HALF_W-1:0]  l16,
    input  logic [DES_HALF_W-1:0]  r16,
    output logic [DES_BLOCK_W-1:0] fp_out
);

    assign fp_out = fp_permute({r16, l16});

endmodule

// File: rtl/des_fp_tx.sv
// DES output stage: FP of (L16,R16) serialized as eight bytes, MSB first, over valid/ready.
// Optional DES_FP_PREFETCH_EN adds a one-block holding register for gapless back-to-back blocks.
//
// state | meaning
// IDLE  | no block in the shift register, ready for a new pair
// SEND  | shift[63:56] presented as byte cnt of the current block
module des_fp_tx
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    des_fp_tx_if.slave  bus,
    output logic        busy
);

    tx_state_t              state, state_n;
    logic [2:0]             cnt, cnt_n;
    logic [DES_BLOCK_W-1:0] shift, shift_n;
    logic [DES_BLOCK_W-1:0] fp_res;
    logic                   in_fire, out_fire, last_fire;

`ifdef DES_FP_PREFETCH_EN
    logic [DES_BLOCK_W-1:0] hold, hold_n;
    logic                   hold_full, hold_full_n;
`endif

    des_fp u_fp (
        .l16    (bus.l16),
        .r16    (bus.r16),
        .fp_out (fp_res)
    );

    assign bus.out_valid = (state == SEND);
    assign bus.out_data  = shift[63:56];
    assign bus.out_last  = (state == SEND) && (cnt == 3'd7);
`ifdef DES_FP_PREFETCH_EN
    assign bus.in_ready  = !hold_full;
    assign busy          = (state == SEND) || hold_full;
`else
    assign bus.in_ready  = (state == IDLE);
    assign busy          = (state == SEND);
`endif

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign out_fire  = bus.out_valid && bus.out_ready;
    assign last_fire = out_fire && (cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shift     <= '0;
`ifdef DES_FP_PREFETCH_EN
            hold      <= '0;
            hold_full <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shift     <= shift_n;
`ifdef DES_FP_PREFETCH_EN
            hold      <= hold_n;
            hold_full <= hold_full_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shift_n     = shift;
`ifdef DES_FP_PREFETCH_EN
        hold_n      = hold;
        hold_full_n = hold_full;
`endif
        case (state)
            IDLE: begin
                if (in_fire) begin
                    shift_n = fp_res;
                    cnt_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (out_fire) begin
                    shift_n = {shift[55:0], 8'h00};
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
`ifdef DES_FP_PREFETCH_EN
                        // held block wins; in_ready is low then, so no same-edge accept
                        if (hold_full) begin
                            shift_n     = hold;
                            hold_full_n = 1'b0;
                            cnt_n       = '0;
                        end else if (in_fire) begin
                            shift_n = fp_res;
                            cnt_n   = '0;
                        end else begin
                            state_n = IDLE;
                        end
`else
                        state_n = IDLE;
`endif
                    end
                end
`ifdef DES_FP_PREFETCH_EN
                if (in_fire && !last_fire) begin
                    hold_n      = fp_res;
                    hold_full_n = 1'b1;
                end
`endif
            end
        endcase
    end

endmodule
